reorder_buffer: RTL and testbench
=================================

REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 Parameter ROB_DEPTH, default 16, number of entries; power of two, at least 4.
REQ-002 Parameter PREG_W, default 7, physical register tag width; ROB_TAG_W = log2(ROB_DEPTH).
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 alloc_valid_i  in  1  dispatch presents an instruction for allocation.
REQ-006 alloc_ready_o  out  1  buffer can accept an allocation this cycle.
REQ-007 alloc_pc_i  in  32 / alloc_rd_used_i  in  1 / alloc_rd_new_i  in  PREG_W / alloc_rd_old_i  in  PREG_W  fields of the allocated instruction.
REQ-008 alloc_tag_o  out  ROB_TAG_W  tag assigned to the allocation (current tail index).
REQ-009 wb_valid_i  in  1 / wb_tag_i  in  ROB_TAG_W  execution-complete notification from the writeback bus.
REQ-010 commit_valid_o  out  1 / commit_ready_i  in  1  head-entry retirement handshake toward the commit unit.
REQ-011 commit_tag_o  out  ROB_TAG_W / commit_pc_o  out  32 / commit_rd_used_o  out  1 / commit_rd_new_o  out  PREG_W / commit_rd_old_o  out  PREG_W  head-entry fields.
REQ-012 flush_i  in  1  discard all entries.
REQ-013 count_o  out  ROB_TAG_W+1 / full_o  out  1 / empty_o  out  1  occupancy status.

Function
REQ-014 Circular buffer; head and tail pointers carry one extra wrap bit; full when indices are equal and wrap bits differ; empty when both are equal.
REQ-015 alloc_ready_o = !full_o, derived only from registered state, independent of commit_ready_i (no alloc into a slot freed the same cycle).
REQ-016 On alloc fire (valid && ready), write fields to the tail entry, set valid=1 and done=0, and advance the tail; alloc_tag_o equals the tail index before the advance.
REQ-017 On wb_valid_i, set done on entry wb_tag_i if that entry is valid; a writeback to an invalid entry is silently ignored.
REQ-018 commit_valid_o = head entry valid && done, derived from registered state only; commit_* outputs show the head entry whenever commit_valid_o is 1.
REQ-019 On commit fire (valid && ready), clear the head entry's valid bit and advance the head; at most one commit per cycle.
REQ-020 Latency: alloc in cycle N, wb in cycle N+1, commit_valid_o high in cycle N+2 at the earliest.
REQ-021 Simultaneous alloc and commit when not full: both take effect; count_o is unchanged.
REQ-022 Pointer wrap: index rolls from ROB_DEPTH-1 to 0 and toggles the wrap bit.
REQ-023 flush_i has highest priority; the next cycle has all valid bits clear, head=tail=0, and count_o=0; same-cycle alloc, writeback and commit are discarded.
REQ-024 count_o = tail - head with wrap bits, range 0..ROB_DEPTH.

Reset
REQ-025 Asserting rst_n low, at any time including mid-operation, immediately clears all valid and done bits and sets head=tail=0.
REQ-026 Reset output values: alloc_ready_o=1, commit_valid_o=0, empty_o=1, full_o=0, count_o=0, alloc_tag_o=0.
REQ-027 Entry payload fields (pc, rd_*) are not reset; outputs are don't-care while commit_valid_o=0.

Structure
REQ-028 rob_entry_t (valid, done, pc, rd_used, rd_new, rd_old) and the ROB_DEPTH, ROB_TAG_W and PREG_W constants live in the shared ooop types package.
REQ-029 Single flat module; no sub-module; entry storage is a register array.

Verification
REQ-030 Reset, then alloc pc=0x00,0x04,0x08 on consecutive cycles -> tags 0,1,2, count_o=3, commit_valid_o=0.
REQ-031 wb tag 1, then tag 0, with commit_ready_i=1 -> no commit after tag 1 alone; after tag 0, commits tag 0 (pc 0x00) then tag 1 (pc 0x04) on consecutive cycles; tag 2 is held.
REQ-032 Allocate 16 entries without writeback -> full_o=1, alloc_ready_o=0; a 17th alloc_valid_i is not accepted and the tail is unchanged.
REQ-033 Fill the buffer, wb all, commit_ready_i=1, alloc each cycle for 40 cycles -> tags wrap 15->0, commit order matches alloc order, count_o stays steady.
REQ-034 Mid-stream flush_i with alloc_valid_i and wb_valid_i high -> next cycle count_o=0, empty_o=1, commit_valid_o=0; the next alloc gets tag 0.
REQ-035 rst_n low for 1 ns between clock edges with 5 entries live -> outputs immediately match REQ-026.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// Shared out-of-order pipeline types: reorder-buffer geometry and entry layout.
package reorder_buffer_pkg;

  localparam int unsigned ROB_DEPTH = 16;
  localparam int unsigned PREG_W    = 7;
  localparam int unsigned ROB_TAG_W = $clog2(ROB_DEPTH);

  typedef struct packed {
    logic              valid;
    logic              done;
    logic [31:0]       pc;
    logic              rd_used;
    logic [PREG_W-1:0] rd_new;
    logic [PREG_W-1:0] rd_old;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// Reorder buffer: in-order allocation and retirement over a circular entry array,
// with out-of-order completion marking from the writeback bus.
module reorder_buffer #(
  parameter int unsigned  ROB_DEPTH = reorder_buffer_pkg::ROB_DEPTH,
  parameter int unsigned  PREG_W    = reorder_buffer_pkg::PREG_W,
  localparam int unsigned ROB_TAG_W = $clog2(ROB_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,

  input  logic                 alloc_valid_i,
  output logic                 alloc_ready_o,
  input  logic [31:0]          alloc_pc_i,
  input  logic                 alloc_rd_used_i,
  input  logic [PREG_W-1:0]    alloc_rd_new_i,
  input  logic [PREG_W-1:0]    alloc_rd_old_i,
  output logic [ROB_TAG_W-1:0] alloc_tag_o,

  input  logic                 wb_valid_i,
  input  logic [ROB_TAG_W-1:0] wb_tag_i,

  output logic                 commit_valid_o,
  input  logic                 commit_ready_i,
  output logic [ROB_TAG_W-1:0] commit_tag_o,
  output logic [31:0]          commit_pc_o,
  output logic                 commit_rd_used_o,
  output logic [PREG_W-1:0]    commit_rd_new_o,
  output logic [PREG_W-1:0]    commit_rd_old_o,

  input  logic                 flush_i,

  output logic [ROB_TAG_W:0]   count_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam logic [ROB_TAG_W:0] PTR_ONE = {{ROB_TAG_W{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit above the index.
  logic [ROB_TAG_W:0]   head_q, tail_q;
  logic [ROB_DEPTH-1:0] valid_q, done_q;

  logic [31:0]          pc_q      [ROB_DEPTH];
  logic                 rd_used_q [ROB_DEPTH];
  logic [PREG_W-1:0]    rd_new_q  [ROB_DEPTH];
  logic [PREG_W-1:0]    rd_old_q  [ROB_DEPTH];

  logic [ROB_TAG_W-1:0] head_idx, tail_idx;
  logic                 full, empty;
  logic                 alloc_fire, commit_fire, commit_valid;

  always_comb begin
    head_idx     = head_q[ROB_TAG_W-1:0];
    tail_idx     = tail_q[ROB_TAG_W-1:0];
    full         = (head_idx == tail_idx) && (head_q[ROB_TAG_W] != tail_q[ROB_TAG_W]);
    empty        = (head_q == tail_q);
    commit_valid = valid_q[head_idx] && done_q[head_idx];
    // Readiness looks only at registered occupancy, never at this cycle's commit.
    alloc_fire   = alloc_valid_i && !full;
    commit_fire  = commit_valid && commit_ready_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
      done_q  <= '0;
    end else if (flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      // Alloc targets an invalid slot, so it never collides with a writeback or commit.
      if (wb_valid_i && valid_q[wb_tag_i]) begin
        done_q[wb_tag_i] <= 1'b1;
      end
      if (alloc_fire) begin
        valid_q[tail_idx] <= 1'b1;
        done_q[tail_idx]  <= 1'b0;
        tail_q            <= tail_q + PTR_ONE;
      end
      if (commit_fire) begin
        valid_q[head_idx] <= 1'b0;
        head_q            <= head_q + PTR_ONE;
      end
    end
  end

  // Payload is qualified by valid/done, so it needs no reset.
  always_ff @(posedge clk) begin
    if (alloc_fire && !flush_i) begin
      pc_q[tail_idx]      <= alloc_pc_i;
      rd_used_q[tail_idx] <= alloc_rd_used_i;
      rd_new_q[tail_idx]  <= alloc_rd_new_i;
      rd_old_q[tail_idx]  <= alloc_rd_old_i;
    end
  end

  always_comb begin
    alloc_ready_o    = !full;
    alloc_tag_o      = tail_idx;
    commit_valid_o   = commit_valid;
    commit_tag_o     = head_idx;
    commit_pc_o      = pc_q[head_idx];
    commit_rd_used_o = rd_used_q[head_idx];
    commit_rd_new_o  = rd_new_q[head_idx];
    commit_rd_old_o  = rd_old_q[head_idx];
    count_o          = tail_q - head_q;
    full_o           = full;
    empty_o          = empty;
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus a randomized
// run against a queue-based reference model.
module tb_reorder_buffer;

  logic        clk;
  logic        rst_n;
  logic        alloc_valid_i;
  logic        alloc_ready_o;
  logic [31:0] alloc_pc_i;
  logic        alloc_rd_used_i;
  logic [6:0]  alloc_rd_new_i;
  logic [6:0]  alloc_rd_old_i;
  logic [3:0]  alloc_tag_o;
  logic        wb_valid_i;
  logic [3:0]  wb_tag_i;
  logic        commit_valid_o;
  logic        commit_ready_i;
  logic [3:0]  commit_tag_o;
  logic [31:0] commit_pc_o;
  logic        commit_rd_used_o;
  logic [6:0]  commit_rd_new_o;
  logic [6:0]  commit_rd_old_o;
  logic        flush_i;
  logic [4:0]  count_o;
  logic        full_o;
  logic        empty_o;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int          tag;
    logic [31:0] pc;
    logic        used;
    logic [6:0]  rn;
    logic [6:0]  ro;
    bit          done;
  } ent_t;

  reorder_buffer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .alloc_valid_i    (alloc_valid_i),
    .alloc_ready_o    (alloc_ready_o),
    .alloc_pc_i       (alloc_pc_i),
    .alloc_rd_used_i  (alloc_rd_used_i),
    .alloc_rd_new_i   (alloc_rd_new_i),
    .alloc_rd_old_i   (alloc_rd_old_i),
    .alloc_tag_o      (alloc_tag_o),
    .wb_valid_i       (wb_valid_i),
    .wb_tag_i         (wb_tag_i),
    .commit_valid_o   (commit_valid_o),
    .commit_ready_i   (commit_ready_i),
    .commit_tag_o     (commit_tag_o),
    .commit_pc_o      (commit_pc_o),
    .commit_rd_used_o (commit_rd_used_o),
    .commit_rd_new_o  (commit_rd_new_o),
    .commit_rd_old_o  (commit_rd_old_o),
    .flush_i          (flush_i),
    .count_o          (count_o),
    .full_o           (full_o),
    .empty_o          (empty_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic drive_idle();
    alloc_valid_i   = 1'b0;
    alloc_pc_i      = '0;
    alloc_rd_used_i = 1'b0;
    alloc_rd_new_i  = '0;
    alloc_rd_old_i  = '0;
    wb_valid_i      = 1'b0;
    wb_tag_i        = '0;
    commit_ready_i  = 1'b0;
    flush_i         = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive_idle();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic alloc_drive(input logic [31:0] pc, input logic [6:0] rn, input logic [6:0] ro);
    alloc_valid_i   = 1'b1;
    alloc_pc_i      = pc;
    alloc_rd_used_i = 1'b1;
    alloc_rd_new_i  = rn;
    alloc_rd_old_i  = ro;
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    #3;
    n_cmp++; if (alloc_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_alloc_ready got %b want 1", alloc_ready_o); end
    n_cmp++; if (commit_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_commit_valid got %b want 0", commit_valid_o); end
    n_cmp++; if (empty_o !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b want 1", empty_o); end
    n_cmp++; if (full_o !== 1'b0) begin n_err++; $display("FAIL reset_full got %b want 0", full_o); end
    n_cmp++; if (count_o !== 5'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count_o); end
    n_cmp++; if (alloc_tag_o !== 4'd0) begin n_err++; $display("FAIL reset_alloc_tag got %0d want 0", alloc_tag_o); end
    rst_n = 1'b1;
    tick();
  endtask

  // Three allocations; each tag is checked before the edge that accepts it.
  task automatic test_alloc_basic();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      alloc_drive(32'(i * 4), 7'(10 + i), 7'(20 + i));
      #1;
      n_cmp++; if (alloc_tag_o !== 4'(i)) begin n_err++; $display("FAIL alloc_tag[%0d] got %0d want %0d", i, alloc_tag_o, i); end
      tick();
    end
    drive_idle();
    #1;
    n_cmp++; if (count_o !== 5'd3) begin n_err++; $display("FAIL alloc_count got %0d want 3", count_o); end
    n_cmp++; if (commit_valid_o !== 1'b0) begin n_err++; $display("FAIL alloc_commit_valid got %b want 0", commit_valid_o); end
  endtask

  // Continues from test_alloc_basic: entries 0..2 live, none done.
  task automatic test_wb_commit();
    commit_ready_i = 1'b1;
    wb_valid_i = 1'b1; wb_tag_i = 4'd1;
    tick();
    n_cmp++; if (commit_valid_o !== 1'b0) begin n_err++; $display("FAIL wb1_only_commit got %b want 0", commit_valid_o); end
    wb_tag_i = 4'd0;
    tick();
    wb_valid_i = 1'b0;
    n_cmp++; if (commit_valid_o !== 1'b1 || commit_tag_o !== 4'd0 || commit_pc_o !== 32'h0 || commit_rd_new_o !== 7'd10 || commit_rd_old_o !== 7'd20)
      begin n_err++; $display("FAIL commit0 got v=%b tag=%0d pc=%h new=%0d old=%0d want v=1 tag=0 pc=0 new=10 old=20", commit_valid_o, commit_tag_o, commit_pc_o, commit_rd_new_o, commit_rd_old_o); end
    tick();
    n_cmp++; if (commit_valid_o !== 1'b1 || commit_tag_o !== 4'd1 || commit_pc_o !== 32'h4 || commit_rd_used_o !== 1'b1)
      begin n_err++; $display("FAIL commit1 got v=%b tag=%0d pc=%h used=%b want v=1 tag=1 pc=4 used=1", commit_valid_o, commit_tag_o, commit_pc_o, commit_rd_used_o); end
    tick();
    n_cmp++; if (commit_valid_o !== 1'b0 || count_o !== 5'd1)
      begin n_err++; $display("FAIL hold_tag2 got v=%b count=%0d want v=0 count=1", commit_valid_o, count_o); end
    drive_idle();
  endtask

  task automatic test_latency();
    do_reset();
    commit_ready_i = 1'b0;
    alloc_drive(32'h40, 7'd3, 7'd4);
    tick();
    alloc_valid_i = 1'b0;
    wb_valid_i = 1'b1; wb_tag_i = 4'd0;
    #1;
    n_cmp++; if (commit_valid_o !== 1'b0) begin n_err++; $display("FAIL latency_early got %b want 0", commit_valid_o); end
    tick();
    wb_valid_i = 1'b0;
    n_cmp++; if (commit_valid_o !== 1'b1 || commit_pc_o !== 32'h40)
      begin n_err++; $display("FAIL latency_n2 got v=%b pc=%h want v=1 pc=40", commit_valid_o, commit_pc_o); end
    // A writeback to a never-allocated slot must not mark it complete.
    wb_valid_i = 1'b1; wb_tag_i = 4'd1;
    tick();
    wb_valid_i = 1'b0;
    alloc_drive(32'h44, 7'd5, 7'd6);
    commit_ready_i = 1'b1;
    tick();
    drive_idle();
    commit_ready_i = 1'b1;
    tick();
    n_cmp++; if (commit_valid_o !== 1'b0 || count_o !== 5'd1)
      begin n_err++; $display("FAIL stale_wb got v=%b count=%0d want v=0 count=1", commit_valid_o, count_o); end
    drive_idle();
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      alloc_drive(32'h100 + 32'(i * 4), 7'(i), 7'(i + 1));
      tick();
    end
    n_cmp++; if (full_o !== 1'b1 || alloc_ready_o !== 1'b0 || count_o !== 5'd16 || empty_o !== 1'b0)
      begin n_err++; $display("FAIL full got full=%b ready=%b count=%0d empty=%b want 1 0 16 0", full_o, alloc_ready_o, count_o, empty_o); end
    alloc_drive(32'hdead, 7'd0, 7'd0);
    tick();
    drive_idle();
    n_cmp++; if (count_o !== 5'd16 || alloc_tag_o !== 4'd0 || full_o !== 1'b1)
      begin n_err++; $display("FAIL full_reject got count=%0d tag=%0d full=%b want 16 0 1", count_o, alloc_tag_o, full_o); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q[$];
    int model_cnt, next_tag, prev_tag;
    bit prev_fired, fired;
    logic [31:0] pc;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      alloc_drive(32'h200 + 32'(i * 4), 7'(i), 7'(i));
      exp_q.push_back(32'h200 + 32'(i * 4));
      tick();
    end
    alloc_valid_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wb_valid_i = 1'b1; wb_tag_i = 4'(i);
      tick();
    end
    wb_valid_i = 1'b0;
    model_cnt = 16; next_tag = 0; prev_fired = 0; prev_tag = 0;
    for (int c = 0; c < 40; c++) begin
      pc = 32'h1000 + 32'(c * 4);
      alloc_drive(pc, 7'(c), 7'(c));
      commit_ready_i = 1'b1;
      wb_valid_i = prev_fired; wb_tag_i = 4'(prev_tag);
      #1;
      n_cmp++; if (commit_valid_o !== 1'b1 || commit_pc_o !== exp_q[0])
        begin n_err++; $display("FAIL b2b_commit[%0d] got v=%b pc=%h want v=1 pc=%h", c, commit_valid_o, commit_pc_o, exp_q[0]); end
      n_cmp++; if (count_o !== 5'(model_cnt) || alloc_tag_o !== 4'(next_tag))
        begin n_err++; $display("FAIL b2b_state[%0d] got count=%0d tag=%0d want %0d %0d", c, count_o, alloc_tag_o, model_cnt, next_tag); end
      fired = (model_cnt < 16);
      if (fired) begin
        exp_q.push_back(pc);
        prev_tag = next_tag;
        next_tag = (next_tag + 1) % 16;
      end
      void'(exp_q.pop_front());
      model_cnt = model_cnt + (fired ? 1 : 0) - 1;
      prev_fired = fired;
      tick();
    end
    drive_idle();
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      alloc_drive(32'h300 + 32'(i * 4), 7'(i), 7'(i));
      tick();
    end
    alloc_valid_i = 1'b0;
    wb_valid_i = 1'b1; wb_tag_i = 4'd0;
    tick();
    alloc_drive(32'h9999, 7'd1, 7'd1);
    wb_valid_i = 1'b1; wb_tag_i = 4'd1;
    commit_ready_i = 1'b1;
    flush_i = 1'b1;
    tick();
    drive_idle();
    n_cmp++; if (count_o !== 5'd0 || empty_o !== 1'b1 || commit_valid_o !== 1'b0 || alloc_tag_o !== 4'd0)
      begin n_err++; $display("FAIL flush got count=%0d empty=%b cv=%b tag=%0d want 0 1 0 0", count_o, empty_o, commit_valid_o, alloc_tag_o); end
    alloc_drive(32'h500, 7'd7, 7'd8);
    tick();
    alloc_valid_i = 1'b0;
    wb_valid_i = 1'b1; wb_tag_i = 4'd0;
    tick();
    wb_valid_i = 1'b0;
    n_cmp++; if (commit_valid_o !== 1'b1 || commit_tag_o !== 4'd0 || commit_pc_o !== 32'h500 || count_o !== 5'd1)
      begin n_err++; $display("FAIL post_flush got cv=%b tag=%0d pc=%h count=%0d want 1 0 500 1", commit_valid_o, commit_tag_o, commit_pc_o, count_o); end
    drive_idle();
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      alloc_drive(32'h600 + 32'(i * 4), 7'(i), 7'(i));
      tick();
    end
    alloc_valid_i = 1'b0;
    wb_valid_i = 1'b1; wb_tag_i = 4'd0;
    tick();
    drive_idle();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (alloc_ready_o !== 1'b1 || commit_valid_o !== 1'b0 || empty_o !== 1'b1 || full_o !== 1'b0 || count_o !== 5'd0 || alloc_tag_o !== 4'd0)
      begin n_err++; $display("FAIL async_reset got ready=%b cv=%b empty=%b full=%b count=%0d tag=%0d want 1 0 1 0 0 0", alloc_ready_o, commit_valid_o, empty_o, full_o, count_o, alloc_tag_o); end
    rst_n = 1'b1;
    tick();
    n_cmp++; if (count_o !== 5'd0 || commit_valid_o !== 1'b0)
      begin n_err++; $display("FAIL async_reset_after got count=%0d cv=%b want 0 0", count_o, commit_valid_o); end
  endtask

  task automatic test_random();
    ent_t q[$];
    ent_t e;
    int next_tag;
    bit exp_cv, a_fire, c_fire;
    do_reset();
    next_tag = 0;
    for (int c = 0; c < 800; c++) begin
      alloc_valid_i   = ($urandom % 10) < 6;
      alloc_pc_i      = $urandom;
      alloc_rd_used_i = 1'($urandom);
      alloc_rd_new_i  = 7'($urandom);
      alloc_rd_old_i  = 7'($urandom);
      commit_ready_i  = ($urandom % 10) < 6;
      wb_valid_i      = ($urandom % 10) < 6;
      if (q.size() > 0 && ($urandom % 5) != 0) wb_tag_i = 4'(q[$urandom_range(0, q.size() - 1)].tag);
      else wb_tag_i = 4'($urandom);
      flush_i = ($urandom % 60) == 0;
      #2;
      exp_cv = (q.size() > 0) && q[0].done;
      n_cmp++; if (alloc_ready_o !== (q.size() < 16) || full_o !== (q.size() == 16) || empty_o !== (q.size() == 0))
        begin n_err++; $display("FAIL rnd_status[%0d] got ready=%b full=%b empty=%b for size %0d", c, alloc_ready_o, full_o, empty_o, q.size()); end
      n_cmp++; if (count_o !== 5'(q.size()) || alloc_tag_o !== 4'(next_tag))
        begin n_err++; $display("FAIL rnd_count[%0d] got count=%0d tag=%0d want %0d %0d", c, count_o, alloc_tag_o, q.size(), next_tag); end
      n_cmp++; if (commit_valid_o !== exp_cv)
        begin n_err++; $display("FAIL rnd_cv[%0d] got %b want %b", c, commit_valid_o, exp_cv); end
      if (exp_cv) begin
        n_cmp++; if (commit_tag_o !== 4'(q[0].tag) || commit_pc_o !== q[0].pc || commit_rd_used_o !== q[0].used || commit_rd_new_o !== q[0].rn || commit_rd_old_o !== q[0].ro)
          begin n_err++; $display("FAIL rnd_fields[%0d] got tag=%0d pc=%h u=%b n=%0d o=%0d want tag=%0d pc=%h u=%b n=%0d o=%0d", c, commit_tag_o, commit_pc_o, commit_rd_used_o, commit_rd_new_o, commit_rd_old_o, q[0].tag, q[0].pc, q[0].used, q[0].rn, q[0].ro); end
      end
      if (flush_i) begin
        q.delete();
        next_tag = 0;
      end else begin
        a_fire = alloc_valid_i && (q.size() < 16);
        c_fire = commit_ready_i && exp_cv;
        if (wb_valid_i) foreach (q[k]) if (q[k].tag == int'(wb_tag_i)) q[k].done = 1;
        if (c_fire) void'(q.pop_front());
        if (a_fire) begin
          e.tag = next_tag; e.pc = alloc_pc_i; e.used = alloc_rd_used_i;
          e.rn = alloc_rd_new_i; e.ro = alloc_rd_old_i; e.done = 0;
          q.push_back(e);
          next_tag = (next_tag + 1) % 16;
        end
      end
      tick();
    end
    drive_idle();
  endtask

  initial begin
    drive_idle();
    rst_n = 1'b0;
    test_reset();
    test_alloc_basic();
    test_wb_commit();
    test_latency();
    test_full();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
